hazard_scoreboard: RTL

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/hazard_scoreboard.sv
// Register hazard scoreboard: per-register in-flight write counters gate decode issue,
// plus a stall watchdog and sticky error flags.
module hazard_scoreboard #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int NUM_REGS       = 32,
  parameter int CNT_WIDTH      = 2,
  parameter int STALL_TIMEOUT  = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      uop_valid,
  input  logic [REG_ADDR_WIDTH-1:0] rs1,
  input  logic [REG_ADDR_WIDTH-1:0] rs2,
  input  logic [REG_ADDR_WIDTH-1:0] rd,
  input  logic                      rs1_valid,
  input  logic                      rs2_valid,
  input  logic                      rd_valid,
  input  logic                      system_stall,
  input  logic                      wb_valid,
  input  logic [REG_ADDR_WIDTH-1:0] wb_rd,
  input  logic                      flush,
  output logic                      source_not_ready,
  output logic                      issue_accept,
  output logic [NUM_REGS-1:0]       pending_mask,
  output logic                      stall_timeout,
  output logic                      wb_underflow
);

  localparam logic [CNT_WIDTH-1:0] CntMax = '1;

  typedef enum logic [1:0] {RUN, STALL, TIMEOUT} state_t;

  state_t               state_q;
  logic [15:0]          stallCnt_q;
  logic [15:0]          stallCntInc;
  logic [CNT_WIDTH-1:0] cnt_q [NUM_REGS];
  logic [CNT_WIDTH-1:0] cnt_d [NUM_REGS];
  logic [CNT_WIDTH-1:0] rs1Cnt, rs2Cnt, rdCnt, wbCnt;
  logic                 hazard, incEn, decEn, underflowEv;
  logic                 incHit, decHit;

  // Register 0 and indices beyond NUM_REGS read as an empty counter.
  always_comb begin
    rs1Cnt = '0;
    rs2Cnt = '0;
    rdCnt  = '0;
    wbCnt  = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      if (rs1 == REG_ADDR_WIDTH'(r))   rs1Cnt = cnt_q[r];
      if (rs2 == REG_ADDR_WIDTH'(r))   rs2Cnt = cnt_q[r];
      if (rd == REG_ADDR_WIDTH'(r))    rdCnt  = cnt_q[r];
      if (wb_rd == REG_ADDR_WIDTH'(r)) wbCnt  = cnt_q[r];
    end
  end

  assign hazard = uop_valid & ~flush &
                  ((rs1_valid & (rs1Cnt != '0)) |
                   (rs2_valid & (rs2Cnt != '0)) |
                   (rd_valid & (rd != '0) & (rdCnt == CntMax)));

  assign source_not_ready = hazard;
  assign issue_accept     = uop_valid & ~hazard & ~system_stall & ~flush;
  assign incEn            = issue_accept & rd_valid & (rd != '0);
  assign decEn            = wb_valid & (wb_rd != '0) & (wbCnt != '0);
  assign underflowEv      = wb_valid & (wb_rd != '0) & (wbCnt == '0);

  // A counter never increments past MAX: the WAW check blocks issue at MAX.
  always_comb begin
    incHit = 1'b0;
    decHit = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_d[r] = cnt_q[r];
      incHit   = incEn && (rd == REG_ADDR_WIDTH'(r));
      decHit   = decEn && (wb_rd == REG_ADDR_WIDTH'(r));
      if (r == 0 || flush) begin
        cnt_d[r] = '0;
      end else begin
        case ({incHit, decHit})
          2'b10:   cnt_d[r] = cnt_q[r] + CNT_WIDTH'(1);
          2'b01:   cnt_d[r] = cnt_q[r] - CNT_WIDTH'(1);
          default: cnt_d[r] = cnt_q[r];
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '{default: '0};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    pending_mask = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      pending_mask[r] = (cnt_q[r] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wb_underflow <= 1'b0;
    end else if (underflowEv) begin
      wb_underflow <= 1'b1;
    end
  end

  assign stallCntInc = stallCnt_q + 16'd1;

  // Watchdog: counts consecutive hazard cycles, frozen while the pipeline is globally stalled.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= RUN;
      stallCnt_q    <= '0;
      stall_timeout <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (flush) begin
            stallCnt_q <= '0;
          end else if (hazard) begin
            stallCnt_q <= 16'd1;
            if (16'd1 >= 16'(STALL_TIMEOUT)) begin
              state_q       <= TIMEOUT;
              stall_timeout <= 1'b1;
            end else begin
              state_q <= STALL;
            end
          end
        end
        STALL: begin
          if (flush || !hazard) begin
            state_q    <= RUN;
            stallCnt_q <= '0;
          end else if (!system_stall) begin
            stallCnt_q <= stallCntInc;
            if (stallCntInc >= 16'(STALL_TIMEOUT)) begin
              state_q       <= TIMEOUT;
              stall_timeout <= 1'b1;
            end
          end
        end
        TIMEOUT: begin
          state_q       <= TIMEOUT;
          stall_timeout <= 1'b1;
        end
        default: begin
          state_q    <= RUN;
          stallCnt_q <= '0;
        end
      endcase
    end
  end

endmodule
